// File: rtl/alu_uart_master_if.sv
// -----------------------------------------------------------------------------
// alu_uart_master_if
//   Byte-level UART link between the ALU command master and its UART
//   transmitter/receiver pair.
//
//   Signals:
//     o_tx_start  master -> uart  one-cycle pulse: transmit o_tx_data
//     o_tx_data   master -> uart  byte to transmit, held until i_txDone
//     i_txDone    uart -> master  one-cycle pulse: byte fully transmitted
//     i_rx_data   uart -> master  received byte
//     i_rxDone    uart -> master  one-cycle pulse: i_rx_data is valid
//
//   Handshake: a byte is handed over by a single-cycle o_tx_start pulse
//   (no ready); o_tx_data must stay stable until the transmitter answers
//   with a single-cycle i_txDone. i_rxDone is a single-cycle valid with no
//   back-pressure: a byte the master is not waiting for is simply lost.
//
//   Modports: master (the command master), slave (the UART side).
// -----------------------------------------------------------------------------
interface alu_uart_master_if #(
  parameter int NB_DATA = 8
) ();
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_txDone;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rxDone;

  modport master (
    output o_tx_start,
    output o_tx_data,
    input  i_txDone,
    input  i_rx_data,
    input  i_rxDone
  );

  modport slave (
    input  o_tx_start,
    input  o_tx_data,
    output i_txDone,
    output i_rx_data,
    output i_rxDone
  );
endinterface

// File: rtl/alu_uart_master.sv
// -----------------------------------------------------------------------------
// alu_uart_master
//   Host-side command master for the UART ALU link. Captures one request
//   (A, B, opcode), sends it as three bytes A, B, {zeros,op} through a
//   byte-level UART transmitter, then waits for one result byte from the
//   receiver or gives up after TIMEOUT_CYCLES clocks.
//
//   Optional feature (macro ALU_UART_MASTER_RETRY_EN): on a result timeout
//   the whole request is resent up to MAX_RETRY times before o_timeout.
//
//   Ports:
//     clk          clock, rising edge
//     i_rst        synchronous active-high reset
//     i_start      request strobe, honoured only in IDLE
//     i_datoA/B    operands, captured on accepted i_start
//     i_operation  opcode, captured on accepted i_start
//     uart         UART byte link (master modport)
//     o_result     last received result, held until the next one
//     o_done       one-cycle pulse: o_result updated
//     o_timeout    one-cycle pulse: request abandoned
//     o_busy       high in every state except IDLE
//     o_state      current FSM state (debug)
//
//   All outputs are registered: they are computed from the next state, so
//   each one reflects the state entered on the same clock edge.
// -----------------------------------------------------------------------------
module alu_uart_master #(
  parameter int                    NB_DATA        = 8,
  parameter int                    NB_OP          = 6,
  parameter int                    NB_TIMEOUT     = 24,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT_CYCLES = 24'd10_000_000
`ifdef ALU_UART_MASTER_RETRY_EN
  ,
  parameter int                    MAX_RETRY      = 2
`endif
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NB_DATA-1:0]   i_datoA,
  input  logic [NB_DATA-1:0]   i_datoB,
  input  logic [NB_OP-1:0]     i_operation,
  alu_uart_master_if.master    uart,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic                 o_busy,
  output logic [3:0]           o_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SEND_A   = 4'd1,
    WAIT_A   = 4'd2,
    SEND_B   = 4'd3,
    WAIT_B   = 4'd4,
    SEND_OP  = 4'd5,
    WAIT_OP  = 4'd6,
    WAIT_RES = 4'd7,
    DONE     = 4'd8
  } state_t;

  // Last counter value before the timeout fires; the counter never
  // passes it, so it cannot wrap.
  localparam logic [NB_TIMEOUT-1:0] TC_LAST = TIMEOUT_CYCLES - 1'b1;

  state_t               state_q, state_next;
  logic [NB_DATA-1:0]   a_q, a_next;
  logic [NB_DATA-1:0]   b_q, b_next;
  logic [NB_DATA-1:0]   op_q, op_next;
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_next;
  logic                 tx_start_next;
  logic [NB_DATA-1:0]   tx_data_next;
  logic [NB_DATA-1:0]   result_next;
  logic                 done_next;
  logic                 timeout_next;

`ifdef ALU_UART_MASTER_RETRY_EN
  localparam int NB_RETRY = $clog2(MAX_RETRY + 1);
  logic [NB_RETRY-1:0]  retry_q, retry_next;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q         <= IDLE;
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      cnt_q           <= '0;
      uart.o_tx_start <= 1'b0;
      uart.o_tx_data  <= '0;
      o_result        <= '0;
      o_done          <= 1'b0;
      o_timeout       <= 1'b0;
      o_busy          <= 1'b0;
`ifdef ALU_UART_MASTER_RETRY_EN
      retry_q         <= '0;
`endif
    end else begin
      state_q         <= state_next;
      a_q             <= a_next;
      b_q             <= b_next;
      op_q            <= op_next;
      cnt_q           <= cnt_next;
      uart.o_tx_start <= tx_start_next;
      uart.o_tx_data  <= tx_data_next;
      o_result        <= result_next;
      o_done          <= done_next;
      o_timeout       <= timeout_next;
      o_busy          <= (state_next != IDLE);
`ifdef ALU_UART_MASTER_RETRY_EN
      retry_q         <= retry_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_q;
    a_next        = a_q;
    b_next        = b_q;
    op_next       = op_q;
    cnt_next      = cnt_q;
    tx_start_next = 1'b0;
    tx_data_next  = uart.o_tx_data;
    result_next   = o_result;
    done_next     = 1'b0;
    timeout_next  = 1'b0;
`ifdef ALU_UART_MASTER_RETRY_EN
    retry_next    = retry_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          a_next        = i_datoA;
          b_next        = i_datoB;
          op_next       = {{(NB_DATA-NB_OP){1'b0}}, i_operation};
          // The operand register is written on this same edge, so the
          // first byte comes straight from the input.
          tx_start_next = 1'b1;
          tx_data_next  = i_datoA;
          state_next    = SEND_A;
`ifdef ALU_UART_MASTER_RETRY_EN
          retry_next    = '0;
`endif
        end
      end
      SEND_A:  state_next = WAIT_A;
      WAIT_A: begin
        if (uart.i_txDone) begin
          tx_start_next = 1'b1;
          tx_data_next  = b_q;
          state_next    = SEND_B;
        end
      end
      SEND_B:  state_next = WAIT_B;
      WAIT_B: begin
        if (uart.i_txDone) begin
          tx_start_next = 1'b1;
          tx_data_next  = op_q;
          state_next    = SEND_OP;
        end
      end
      SEND_OP: state_next = WAIT_OP;
      WAIT_OP: begin
        if (uart.i_txDone) begin
          cnt_next   = '0;
          state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result arriving on the terminal cycle still wins.
        if (uart.i_rxDone) begin
          result_next = uart.i_rx_data;
          done_next   = 1'b1;
          state_next  = DONE;
        end else if (cnt_q == TC_LAST) begin
`ifdef ALU_UART_MASTER_RETRY_EN
          if (retry_q < NB_RETRY'(MAX_RETRY)) begin
            retry_next    = retry_q + 1'b1;
            tx_start_next = 1'b1;
            tx_data_next  = a_q;
            state_next    = SEND_A;
          end else begin
            timeout_next = 1'b1;
            state_next   = IDLE;
          end
`else
          timeout_next = 1'b1;
          state_next   = IDLE;
`endif
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_state = state_q;

endmodule
